// File: rtl/fetch_sequencer.sv
// Fetch sequencer: four-phase strobe generator, program counter and
// instruction register for the 8-bit core. One instruction cycle is four
// system clocks (Q1..Q4). Jump/skip requests are sampled in Q3 and take
// effect on the Q4->Q1 boundary by inserting a NOP bubble.
module fetch_sequencer #(
    parameter int                    PC_WIDTH   = 8,
    parameter int                    INST_WIDTH = 8,
    parameter logic [INST_WIDTH-1:0] NOP_CODE   = {INST_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  halt,
    input  logic                  jump_en,
    input  logic [PC_WIDTH-1:0]   jump_target,
    input  logic                  skip_en,
    input  logic [INST_WIDTH-1:0] rom_data,
    output logic [PC_WIDTH-1:0]   rom_addr,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [INST_WIDTH-1:0] inst_reg,
    output logic                  fetch_valid,
    output logic                  clk1,
    output logic                  clk2,
    output logic                  clk3,
    output logic                  clk4
);

    typedef enum logic [1:0] {
        PH_Q1 = 2'd0,
        PH_Q2 = 2'd1,
        PH_Q3 = 2'd2,
        PH_Q4 = 2'd3
    } phase_e;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    phase_e                  phase_q,     phase_d;
    logic [3:0]              strobe_q,    strobe_d;
    logic [PC_WIDTH-1:0]     pc_q,        pc_d;
    logic [INST_WIDTH-1:0]   inst_q,      inst_d;
    logic                    valid_q,     valid_d;
    logic                    jump_pend_q, jump_pend_d;
    logic                    skip_pend_q, skip_pend_d;
    logic [PC_WIDTH-1:0]     target_q,    target_d;

    // State register: every piece of architectural state lives here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= PH_Q1;
            strobe_q    <= 4'b0001;
            pc_q        <= {PC_WIDTH{1'b0}};
            inst_q      <= NOP_CODE;
            valid_q     <= 1'b0;
            jump_pend_q <= 1'b0;
            skip_pend_q <= 1'b0;
            target_q    <= {PC_WIDTH{1'b0}};
        end else begin
            phase_q     <= phase_d;
            strobe_q    <= strobe_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            valid_q     <= valid_d;
            jump_pend_q <= jump_pend_d;
            skip_pend_q <= skip_pend_d;
            target_q    <= target_d;
        end
    end

    // Next-state logic: phase rotation, Q3 request capture, boundary update.
    always_comb begin
        phase_d     = phase_q;
        strobe_d    = strobe_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        valid_d     = valid_q;
        jump_pend_d = jump_pend_q;
        skip_pend_d = skip_pend_q;
        target_d    = target_q;

        // Phase advances unconditionally, halt only freezes the datapath.
        case (phase_q)
            PH_Q1:   phase_d = PH_Q2;
            PH_Q2:   phase_d = PH_Q3;
            PH_Q3:   phase_d = PH_Q4;
            PH_Q4:   phase_d = PH_Q1;
            default: phase_d = PH_Q1;
        endcase

        // Strobes are registered from the next phase so they never glitch.
        case (phase_d)
            PH_Q1:   strobe_d = 4'b0001;
            PH_Q2:   strobe_d = 4'b0010;
            PH_Q3:   strobe_d = 4'b0100;
            PH_Q4:   strobe_d = 4'b1000;
            default: strobe_d = 4'b0001;
        endcase

        if (phase_q == PH_Q3) begin
            // Requests accumulate; a halted boundary keeps them pending.
            jump_pend_d = jump_pend_q | jump_en;
            skip_pend_d = skip_pend_q | skip_en;
            if (jump_en) begin
                target_d = jump_target;
            end else begin
                target_d = target_q;
            end
        end else if ((phase_q == PH_Q4) && !halt) begin
            jump_pend_d = 1'b0;
            skip_pend_d = 1'b0;
            if (jump_pend_q) begin
                // Jump outranks skip; a simultaneous skip is dropped.
                pc_d    = target_q;
                inst_d  = NOP_CODE;
                valid_d = 1'b0;
            end else if (skip_pend_q) begin
                // The word fetched this cycle is discarded.
                pc_d    = pc_q + PC_ONE;
                inst_d  = NOP_CODE;
                valid_d = 1'b0;
            end else begin
                pc_d    = pc_q + PC_ONE;
                inst_d  = rom_data;
                valid_d = 1'b1;
            end
        end else begin
            pc_d    = pc_q;
            inst_d  = inst_q;
            valid_d = valid_q;
        end
    end

    assign rom_addr    = pc_q;
    assign pc          = pc_q;
    assign inst_reg    = inst_q;
    assign fetch_valid = valid_q;
    assign clk1        = strobe_q[0];
    assign clk2        = strobe_q[1];
    assign clk3        = strobe_q[2];
    assign clk4        = strobe_q[3];

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a reference model and a
// scoreboard queue of expected per-cycle results.
module tb_fetch_sequencer;

    logic       clk;
    logic       rst_n;
    logic       halt;
    logic       jump_en;
    logic [7:0] jump_target;
    logic       skip_en;
    logic [7:0] rom_data;
    logic [7:0] rom_addr;
    logic [7:0] pc;
    logic [7:0] inst_reg;
    logic       fetch_valid;
    logic       clk1, clk2, clk3, clk4;

    logic [7:0] rom [256];

    typedef struct {
        logic [7:0] pc;
        logic [7:0] inst;
        logic       valid;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    logic [7:0] pc_m;
    logic [7:0] inst_m;
    logic       valid_m;
    logic       jp_m;
    logic       sp_m;
    logic [7:0] tgt_m;

    int tests_run;
    int tests_failed;

    fetch_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .halt        (halt),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .skip_en     (skip_en),
        .rom_data    (rom_data),
        .rom_addr    (rom_addr),
        .pc          (pc),
        .inst_reg    (inst_reg),
        .fetch_valid (fetch_valid),
        .clk1        (clk1),
        .clk2        (clk2),
        .clk3        (clk3),
        .clk4        (clk4)
    );

    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pc_m    = 8'h00;
        inst_m  = 8'h00;
        valid_m = 1'b0;
        jp_m    = 1'b0;
        sp_m    = 1'b0;
        tgt_m   = 8'h00;
    endtask

    // One instruction cycle, entered just after a boundary edge (phase Q1).
    task automatic do_cycle(input logic jmp, input logic [7:0] tgt,
                            input logic skp, input logic hlt);
        exp_t       e;
        logic [3:0] exp_strobe;
        if (jmp) begin
            jp_m  = 1'b1;
            tgt_m = tgt;
        end
        if (skp) sp_m = 1'b1;
        if (!hlt) begin
            if (jp_m) begin
                pc_m = tgt_m; inst_m = 8'h00; valid_m = 1'b0;
            end else if (sp_m) begin
                pc_m = pc_m + 8'd1; inst_m = 8'h00; valid_m = 1'b0;
            end else begin
                inst_m = rom[pc_m]; pc_m = pc_m + 8'd1; valid_m = 1'b1;
            end
            jp_m = 1'b0;
            sp_m = 1'b0;
        end
        e.pc = pc_m; e.inst = inst_m; e.valid = valid_m;
        sb_q.push_back(e);

        for (int p = 0; p < 4; p++) begin
            halt        = hlt;
            jump_en     = (p == 2) ? jmp : 1'b0;
            skip_en     = (p == 2) ? skp : 1'b0;
            jump_target = (p == 2) ? tgt : 8'hA5;
            exp_strobe  = 4'b0001 << p;
            @(negedge clk);
            check("strobe", {28'd0, clk4, clk3, clk2, clk1}, {28'd0, exp_strobe});
            @(posedge clk);
            #1;
        end
        jump_en = 1'b0;
        skip_en = 1'b0;

        e = sb_q.pop_front();
        check("pc",       {24'd0, pc},          {24'd0, e.pc});
        check("rom_addr", {24'd0, rom_addr},    {24'd0, e.pc});
        check("inst_reg", {24'd0, inst_reg},    {24'd0, e.inst});
        check("valid",    {31'd0, fetch_valid}, {31'd0, e.valid});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"},    {24'd0, pc},       32'h0);
        check({tag, "_inst"},  {24'd0, inst_reg}, 32'h0);
        check({tag, "_valid"}, {31'd0, fetch_valid}, 32'h0);
        check({tag, "_strobe"}, {28'd0, clk4, clk3, clk2, clk1}, 32'h1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < 256; i++) rom[i] = 8'((i * 37) + 11);
        rom[0] = 8'h1C; rom[1] = 8'hC5; rom[2] = 8'h08; rom[3] = 8'h3A;
        rst_n = 1'b0; halt = 1'b0; jump_en = 1'b0; skip_en = 1'b0;
        jump_target = 8'h00;
        model_reset();

        @(posedge clk); @(posedge clk); #1;
        check_reset_state("reset");
        rst_n = 1'b1;

        // Straight-line fetch: 1C, C5, 08, 3A then pc 5
        for (int i = 0; i < 5; i++) do_cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Jump to 0x40 sampled at pc=5
        do_cycle(1'b1, 8'h40, 1'b0, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Move to pc=7, skip there, ROM[7] must never appear
        do_cycle(1'b1, 8'h07, 1'b0, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Jump and skip together: one NOP only
        do_cycle(1'b1, 8'h10, 1'b1, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Wrap at 0xFF, then halt for three cycles and resume
        do_cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Jump captured while halted stays pending until release
        do_cycle(1'b1, 8'h30, 1'b0, 1'b1);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Reach pc=0x22 then reset mid-Q2
        do_cycle(1'b1, 8'h22, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
